stoplight_game_ctrl: RTL
========================

STOPLIGHT_GAME_CTRL -- requirements
Module: stoplight_game_ctrl

Interface
REQ-001 Parameter RED_TICKS, default 50_000_000, clock cycles the RED phase lasts.
REQ-002 Parameter GREEN_TICKS, default 25_000_000, clock cycles the GREEN phase lasts.
REQ-003 Parameter YELLOW_TICKS, default 25_000_000, clock cycles the YELLOW phase lasts.
REQ-004 Parameter START_LIVES, default 3, lives loaded at reset and at restart; range 1..7.
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 btn  input  1  raw player button, asynchronous to clk.
REQ-008 led_red, led_yellow, led_green  output  1 each  stoplight lamps, active-high.
REQ-009 digit_tens  output  4  BCD tens digit of score; drives the display's input3.
REQ-010 digit_ones  output  4  BCD ones digit of score; drives the display's input0.
REQ-011 lives  output  3  remaining lives, binary.
REQ-012 game_over  output  1  high while in GAME_OVER state.

Function
REQ-013 btn SHALL pass through a 2-flop synchronizer; a press pulse is one cycle, asserted when synchronized btn is 1 and its previous registered value is 0.
REQ-014 Registered outputs SHALL update on the 3rd rising clk edge after btn is first sampled high (2 sync + 1 update).
REQ-015 States SHALL be RED, GREEN, YELLOW, GAME_OVER; exactly one of led_red/led_green/led_yellow is high in RED/GREEN/YELLOW; in GAME_OVER led_red and led_yellow are high, led_green low.
REQ-016 A phase counter SHALL count 0..TICKS-1 of the current phase; at TICKS-1 the state advances RED->GREEN->YELLOW->RED and the counter returns to 0.
REQ-017 Press in GREEN, first of that phase: score SHALL increment by 1 in BCD (ones 9 wraps to 0 with tens carry); later presses in the same GREEN phase are ignored.
REQ-018 Score SHALL saturate at tens=9, ones=9; a scoring press at 99 leaves 99.
REQ-019 Press in RED, first of that phase: lives SHALL decrement by 1; later presses in the same RED phase are ignored.
REQ-020 Decrement taking lives to 0 SHALL enter GAME_OVER on the same edge; phase counter cleared.
REQ-021 Presses in YELLOW SHALL have no effect.
REQ-022 Press coincident with phase-timer expiry SHALL be credited to the expiring phase, and the transition still occurs on that edge.
REQ-023 GAME_OVER SHALL hold score and lives=0; timer stopped; a press SHALL clear score to 00, reload START_LIVES, enter RED with counter 0.
REQ-024 Per-phase "already pressed" flags SHALL clear on every phase transition.
REQ-025 digit_tens and digit_ones SHALL never hold values above 9.

Reset
REQ-026 reset SHALL asynchronously force: state RED, phase counter 0, score 00, lives START_LIVES, press flags 0, synchronizer flops 0, led_red 1, led_green 0, led_yellow 0, game_over 0.
REQ-027 Reset asserted mid-phase or in GAME_OVER SHALL discard all progress; first edge after release counts as RED cycle 0.

Structure
REQ-028 Package stoplight_pkg SHALL hold the state enum, BCD digit width (4), lives width (3) and BCD max digit (9).
REQ-029 Synchronizer plus edge detector SHALL be a sub-module named button_sync (ports clk, reset, btn_in, press).
REQ-030 Phase timer, FSM and BCD score SHALL reside in stoplight_game_ctrl; phase counter width SHALL be $clog2 of the largest TICKS parameter.

Verification (RED_TICKS=8, GREEN_TICKS=4, YELLOW_TICKS=2, START_LIVES=3)
REQ-031 Reset, no btn -> sequence RED 8 cycles, GREEN 4, YELLOW 2, repeating; digits 0/0, lives 3.
REQ-032 Two presses in one GREEN -> digits 0/1 exactly 3 edges after first btn sample; second press ignored; next GREEN press -> 0/2.
REQ-033 Preload score 09, green press -> tens 1, ones 0; preload 99, green press -> stays 9/9.
REQ-034 Presses in three consecutive RED phases -> lives 3,2,1,0; game_over high, leds red+yellow, digits frozen; press -> digits 0/0, lives 3, RED.
REQ-035 Press pulse on last GREEN cycle -> score increments and YELLOW entered on same edge; press in YELLOW -> no change.
REQ-036 reset asserted mid-GREEN with score 05 -> immediately RED, 0/0, lives 3, without waiting for clk.

Source files
------------

// File: rtl/stoplight_pkg.sv
// Shared types and constants for the stoplight reaction game.
package stoplight_pkg;

  localparam int BCD_W   = 4;
  localparam int LIVES_W = 3;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_RED       = 2'd0,
    ST_GREEN     = 2'd1,
    ST_YELLOW    = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_t;

  function automatic int max_of3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_sync.sv
// Two-flop synchronizer for the raw button plus a rising-edge detector.
// press is a one-cycle pulse, combinational from the synchronized and delayed copies.
module button_sync (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic press
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign press = r_sync2 & ~r_prev;

endmodule

// File: rtl/stoplight_game_ctrl.sv
// Stoplight reaction game: phase timer, RED/GREEN/YELLOW/GAME_OVER FSM, BCD score and lives.
// Score and lives change on the edge that consumes a synchronized press pulse.
module stoplight_game_ctrl
  import stoplight_pkg::*;
#(
  parameter int RED_TICKS    = 50_000_000,
  parameter int GREEN_TICKS  = 25_000_000,
  parameter int YELLOW_TICKS = 25_000_000,
  parameter int START_LIVES  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn,
  output logic               led_red,
  output logic               led_yellow,
  output logic               led_green,
  output logic [BCD_W-1:0]   digit_tens,
  output logic [BCD_W-1:0]   digit_ones,
  output logic [LIVES_W-1:0] lives,
  output logic               game_over
);

  localparam int MAX_TICKS = max_of3(RED_TICKS, GREEN_TICKS, YELLOW_TICKS);
  localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam logic [CNT_W-1:0]   RED_LAST    = CNT_W'(RED_TICKS - 1);
  localparam logic [CNT_W-1:0]   GREEN_LAST  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0]   YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT  = LIVES_W'(START_LIVES);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_phase_last;
  logic [BCD_W-1:0]   r_tens, w_tens_nxt, r_ones, w_ones_nxt;
  logic [LIVES_W-1:0] r_lives, w_lives_nxt;
  logic               r_red_hit, w_red_hit_nxt, r_green_hit, w_green_hit_nxt;
  logic               w_press, w_last;

  button_sync u_button_sync (
    .clk    (clk),
    .reset  (reset),
    .btn_in (btn),
    .press  (w_press)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RED;
      r_cnt       <= '0;
      r_tens      <= '0;
      r_ones      <= '0;
      r_lives     <= LIVES_INIT;
      r_red_hit   <= 1'b0;
      r_green_hit <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_tens      <= w_tens_nxt;
      r_ones      <= w_ones_nxt;
      r_lives     <= w_lives_nxt;
      r_red_hit   <= w_red_hit_nxt;
      r_green_hit <= w_green_hit_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_tens_nxt      = r_tens;
    w_ones_nxt      = r_ones;
    w_lives_nxt     = r_lives;
    w_red_hit_nxt   = r_red_hit;
    w_green_hit_nxt = r_green_hit;

    case (r_state)
      ST_GREEN:  w_phase_last = GREEN_LAST;
      ST_YELLOW: w_phase_last = YELLOW_LAST;
      default:   w_phase_last = RED_LAST;
    endcase
    w_last = (r_cnt == w_phase_last);

    if (r_state == ST_GAME_OVER) begin
      if (w_press) begin
        w_state_nxt     = ST_RED;
        w_cnt_nxt       = '0;
        w_tens_nxt      = '0;
        w_ones_nxt      = '0;
        w_lives_nxt     = LIVES_INIT;
        w_red_hit_nxt   = 1'b0;
        w_green_hit_nxt = 1'b0;
      end
    end else begin
      w_cnt_nxt = r_cnt + CNT_W'(1);

      if (w_press && (r_state == ST_RED) && !r_red_hit) begin
        w_red_hit_nxt = 1'b1;
        w_lives_nxt   = r_lives - LIVES_W'(1);
      end

      // Score saturates at 99 rather than wrapping.
      if (w_press && (r_state == ST_GREEN) && !r_green_hit) begin
        w_green_hit_nxt = 1'b1;
        if (r_ones != BCD_MAX) begin
          w_ones_nxt = r_ones + BCD_W'(1);
        end else if (r_tens != BCD_MAX) begin
          w_ones_nxt = '0;
          w_tens_nxt = r_tens + BCD_W'(1);
        end
      end

      if (w_last) begin
        w_cnt_nxt       = '0;
        w_red_hit_nxt   = 1'b0;
        w_green_hit_nxt = 1'b0;
        case (r_state)
          ST_RED:   w_state_nxt = ST_GREEN;
          ST_GREEN: w_state_nxt = ST_YELLOW;
          default:  w_state_nxt = ST_RED;
        endcase
      end

      // Losing the last life overrides any phase advance on the same edge.
      if (w_lives_nxt == '0) begin
        w_state_nxt     = ST_GAME_OVER;
        w_cnt_nxt       = '0;
        w_red_hit_nxt   = 1'b0;
        w_green_hit_nxt = 1'b0;
      end
    end
  end

  assign led_red    = (r_state == ST_RED)    || (r_state == ST_GAME_OVER);
  assign led_yellow = (r_state == ST_YELLOW) || (r_state == ST_GAME_OVER);
  assign led_green  = (r_state == ST_GREEN);
  assign game_over  = (r_state == ST_GAME_OVER);
  assign digit_tens = r_tens;
  assign digit_ones = r_ones;
  assign lives      = r_lives;

endmodule
